// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide unit with HI/LO ownership and D-stage stall generation.
// Results are computed at issue, held for a fixed busy window, then committed to HI/LO.
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_start,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err_issue
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    md_op_e             op;
    state_e             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        hi_next, lo_next;
    logic               err_next;
    logic               load;
    logic               is_mult, is_div, is_md_exec;

    logic [63:0]        prod_s, prod_u;
    logic               signed_div;
    logic [31:0]        dvd, dvs, dvs_safe, q_mag, r_mag;
    logic [31:0]        start_hi, start_lo;
    logic               start_valid;

    logic [31:0]        res_hi, res_lo;
    logic               res_valid;

    assign op         = md_op_e'(E_md_op);
    assign is_mult    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div     = (op == OP_DIV)  || (op == OP_DIVU);
    assign is_md_exec = is_mult || is_div;

    assign busy    = (state == BUSY);
    // Issue-cycle term covers the cycle before busy rises.
    assign stall_D = D_md_use & (busy | (E_start & is_md_exec));

    // Signed division runs on magnitudes so the -2^31 / -1 case wraps cleanly.
    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        prod_s     = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
        prod_u     = {32'd0, E_rs} * {32'd0, E_rt};
        signed_div = (op == OP_DIV);
        dvd        = (signed_div && E_rs[31]) ? -E_rs : E_rs;
        dvs        = (signed_div && E_rt[31]) ? -E_rt : E_rt;
        dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
        q_mag      = dvd / dvs_safe;
        r_mag      = dvd % dvs_safe;

        start_hi    = 32'd0;
        start_lo    = 32'd0;
        start_valid = 1'b0;
        case (op)
            OP_MULT: begin
                {start_hi, start_lo} = prod_s;
                start_valid          = 1'b1;
            end
            OP_MULTU: begin
                {start_hi, start_lo} = prod_u;
                start_valid          = 1'b1;
            end
            OP_DIV: begin
                start_lo    = (E_rs[31] ^ E_rt[31]) ? -q_mag : q_mag;
                start_hi    = E_rs[31] ? -r_mag : r_mag;
                start_valid = (E_rt != 32'd0);
            end
            OP_DIVU: begin
                start_lo    = q_mag;
                start_hi    = r_mag;
                start_valid = (E_rt != 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        hi_next    = hi;
        lo_next    = lo;
        err_next   = err_issue;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (E_start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            load       = 1'b1;
                            state_next = BUSY;
                            cnt_next   = CNT_W'(MULT_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            load       = 1'b1;
                            state_next = BUSY;
                            cnt_next   = CNT_W'(DIV_CYCLES - 1);
                        end
                        OP_MTHI: hi_next = E_rs;
                        OP_MTLO: lo_next = E_rs;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                if (E_start) begin
                    err_next = 1'b1;
                end
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    state_next = IDLE;
                    if (res_valid) begin
                        {hi_next, lo_next} = {res_hi, res_lo};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            err_issue <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            hi        <= hi_next;
            lo        <= lo_next;
            err_issue <= err_next;
        end
    end

    // NOTE: the result holding registers need no reset; they are only read after a load.
    always_ff @(posedge clk) begin
        if (load) begin
            res_hi    <= start_hi;
            res_lo    <= start_lo;
            res_valid <= start_valid;
        end
    end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed scenarios plus randomized ops
// compared against a longint-arithmetic reference model of HI/LO.
module tb_md_scheduler;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        E_start;
    logic [2:0]  E_md_op;
    logic [31:0] E_rs, E_rt;
    logic        D_md_use;
    logic        busy, stall_D, err_issue;
    logic [31:0] hi, lo;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_hi, m_lo;

    md_scheduler #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_start   (E_start),
        .E_md_op   (E_md_op),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
        .D_md_use  (D_md_use),
        .busy      (busy),
        .stall_D   (stall_D),
        .hi        (hi),
        .lo        (lo),
        .err_issue (err_issue)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: {hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = {m_hi, m_lo};
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3: if (b != 32'd0) begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            3'd4: if (b != 32'd0) begin
                uq = ua / ub;
                ur = ua % ub;
                r  = {ur[31:0], uq[31:0]};
            end
            3'd5: r[63:32] = a;
            3'd6: r[31:0]  = a;
            default: ;
        endcase
        return r;
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        {m_hi, m_lo} = ref_md(op, a, b);
    endtask

    // Issue a mult/div at the current negedge and follow its busy window.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic d_use, output int cycles, output int stall_bad, output int hold_bad);
        logic [31:0] old_hi, old_lo;
        old_hi    = hi;
        old_lo    = lo;
        stall_bad = 0;
        hold_bad  = 0;
        E_start   = 1'b1;
        E_md_op   = op;
        E_rs      = a;
        E_rt      = b;
        D_md_use  = d_use;
        #1;
        if (stall_D !== d_use) stall_bad++;
        @(negedge clk);
        E_start = 1'b0;
        E_md_op = 3'd0;
        E_rs    = $urandom;
        E_rt    = $urandom;
        cycles  = 0;
        while (busy === 1'b1 && cycles < 64) begin
            #1;
            if (stall_D !== d_use) stall_bad++;
            if (hi !== old_hi || lo !== old_lo) hold_bad++;
            cycles++;
            @(negedge clk);
        end
    endtask

    // Single-cycle issue of a non-busy op (MT or NONE).
    task automatic run_short(input logic [2:0] op, input logic [31:0] a, input logic d_use,
                             output logic stall_obs, output logic busy_obs);
        E_start  = 1'b1;
        E_md_op  = op;
        E_rs     = a;
        E_rt     = $urandom;
        D_md_use = d_use;
        #1;
        stall_obs = stall_D;
        @(negedge clk);
        E_start  = 1'b0;
        E_md_op  = 3'd0;
        D_md_use = 1'b0;
        busy_obs = busy;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        E_start  = 1'b0;
        E_md_op  = 3'd0;
        E_rs     = 32'd0;
        E_rt     = 32'd0;
        D_md_use = 1'b0;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else n_pass++;
        n_total++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else n_pass++;
        n_total++; if (err_issue !== 1'b0) $display("FAIL reset_err: got %b want 0", err_issue); else n_pass++;
        D_md_use = 1'b1;
        #1;
        n_total++; if (stall_D !== 1'b0) $display("FAIL reset_stall_idle: got %b want 0", stall_D); else n_pass++;
        reset = 1'b0;
        D_md_use = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_mult_basic();
        int cyc, sb, hb;
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, cyc, sb, hb);
        D_md_use = 1'b0;
        model_apply(3'd1, 32'hFFFF_FFFE, 32'd3);
        n_total++; if (cyc != MULT_N) $display("FAIL mult_busy_cycles: got %0d want %0d", cyc, MULT_N); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h want ffffffff", hi); else n_pass++;
        n_total++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mult_lo: got %h want fffffffa", lo); else n_pass++;
        n_total++; if (sb != 0 || hb != 0) $display("FAIL mult_window: stall errs %0d hold errs %0d want 0", sb, hb); else n_pass++;
    endtask

    task automatic test_divu_stall();
        int cyc, sb, hb;
        run_op(3'd4, 32'd100, 32'd7, 1'b1, cyc, sb, hb);
        D_md_use = 1'b0;
        model_apply(3'd4, 32'd100, 32'd7);
        n_total++; if (cyc != DIV_N) $display("FAIL divu_busy_cycles: got %0d want %0d", cyc, DIV_N); else n_pass++;
        n_total++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h want 0000000e", lo); else n_pass++;
        n_total++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h want 00000002", hi); else n_pass++;
        n_total++; if (sb != 0) $display("FAIL divu_stall_used: %0d cycles with stall_D != 1", sb); else n_pass++;
        n_total++; if (hb != 0) $display("FAIL divu_hold: hi/lo changed in %0d busy cycles", hb); else n_pass++;
        run_op(3'd4, 32'd100, 32'd7, 1'b0, cyc, sb, hb);
        model_apply(3'd4, 32'd100, 32'd7);
        n_total++; if (sb != 0) $display("FAIL divu_stall_unused: %0d cycles with stall_D != 0", sb); else n_pass++;
        n_total++; if (cyc != DIV_N) $display("FAIL divu2_busy_cycles: got %0d want %0d", cyc, DIV_N); else n_pass++;
    endtask

    task automatic test_div_signed();
        int cyc, sb, hb;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, cyc, sb, hb);
        model_apply(3'd3, 32'hFFFF_FFF9, 32'd2);
        n_total++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h want fffffffd", lo); else n_pass++;
        n_total++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h want ffffffff", hi); else n_pass++;
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc, sb, hb);
        model_apply(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        n_total++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h want 80000000", lo); else n_pass++;
        n_total++; if (hi !== 32'd0) $display("FAIL div_ovf_hi: got %h want 00000000", hi); else n_pass++;
        n_total++; if (cyc != DIV_N) $display("FAIL div_ovf_cycles: got %0d want %0d", cyc, DIV_N); else n_pass++;
    endtask

    task automatic test_mt_div0();
        int cyc, sb, hb;
        logic st, bz;
        run_short(3'd5, 32'h11, 1'b1, st, bz);
        model_apply(3'd5, 32'h11, 32'd0);
        n_total++; if (bz !== 1'b0) $display("FAIL mthi_busy: got %b want 0", bz); else n_pass++;
        n_total++; if (st !== 1'b0) $display("FAIL mthi_stall: got %b want 0", st); else n_pass++;
        n_total++; if (hi !== 32'h11) $display("FAIL mthi_hi: got %h want 00000011", hi); else n_pass++;
        run_short(3'd6, 32'h22, 1'b0, st, bz);
        model_apply(3'd6, 32'h22, 32'd0);
        n_total++; if (lo !== 32'h22 || bz !== 1'b0) $display("FAIL mtlo: lo %h busy %b want 00000022/0", lo, bz); else n_pass++;
        run_op(3'd3, 32'd5, 32'd0, 1'b0, cyc, sb, hb);
        model_apply(3'd3, 32'd5, 32'd0);
        n_total++; if (cyc != DIV_N) $display("FAIL div0_cycles: got %0d want %0d", cyc, DIV_N); else n_pass++;
        n_total++; if (hi !== 32'h11 || lo !== 32'h22) $display("FAIL div0_keep: hi %h lo %h want 00000011/00000022", hi, lo); else n_pass++;
    endtask

    task automatic test_err_issue();
        int cyc;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom_range(1, 32'h0000_FFFF);
        n_total++; if (err_issue !== 1'b0) $display("FAIL err_pre: got %b want 0", err_issue); else n_pass++;
        E_start = 1'b1;
        E_md_op = 3'd3;
        E_rs    = a;
        E_rt    = b;
        @(negedge clk);
        E_start = 1'b0;
        E_md_op = 3'd0;
        cyc     = 0;
        while (busy === 1'b1 && cyc < 64) begin
            cyc++;
            if (cyc == 4) begin
                E_start = 1'b1;
                E_md_op = 3'd1;
                E_rs    = $urandom;
                E_rt    = $urandom;
            end else begin
                E_start = 1'b0;
                E_md_op = 3'd0;
            end
            @(negedge clk);
        end
        E_start = 1'b0;
        E_md_op = 3'd0;
        model_apply(3'd3, a, b);
        n_total++; if (err_issue !== 1'b1) $display("FAIL err_set: got %b want 1", err_issue); else n_pass++;
        n_total++; if (cyc != DIV_N) $display("FAIL err_div_cycles: got %0d want %0d", cyc, DIV_N); else n_pass++;
        n_total++; if (hi !== m_hi || lo !== m_lo) $display("FAIL err_div_result: hi %h lo %h want %h/%h", hi, lo, m_hi, m_lo); else n_pass++;
        repeat (3) @(negedge clk);
        n_total++; if (err_issue !== 1'b1) $display("FAIL err_sticky: got %b want 1", err_issue); else n_pass++;
    endtask

    task automatic test_reset_abort();
        E_start = 1'b1;
        E_md_op = 3'd2;
        E_rs    = 32'hFFFF_FFFF;
        E_rt    = 32'hFFFF_FFFF;
        @(negedge clk);
        E_start = 1'b0;
        E_md_op = 3'd0;
        repeat (2) @(negedge clk);
        n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_c3: got %b want 1", busy); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_total++; if (hi !== 32'd0 || lo !== 32'd0) $display("FAIL abort_clear: hi %h lo %h want 0/0", hi, lo); else n_pass++;
        n_total++; if (err_issue !== 1'b0) $display("FAIL abort_err: got %b want 0", err_issue); else n_pass++;
        repeat (12) @(negedge clk);
        n_total++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL abort_no_commit: busy %b hi %h lo %h want 0/0/0", busy, hi, lo); else n_pass++;
    endtask

    // Random op stream issued back to back, checked against the reference model.
    task automatic test_random();
        int          cyc, sb, hb, exp_n;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        d_use, st, bz;
        for (int i = 0; i < 40; i++) begin
            op    = 3'($urandom_range(0, 7));
            a     = $urandom;
            b     = $urandom;
            d_use = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: a = 32'hFFFF_FFFF;
                3: b = $urandom_range(1, 300);
                default: ;
            endcase
            if (op >= 3'd1 && op <= 3'd4) begin
                run_op(op, a, b, d_use, cyc, sb, hb);
                D_md_use = 1'b0;
                model_apply(op, a, b);
                exp_n = (op <= 3'd2) ? MULT_N : DIV_N;
                n_total++; if (cyc != exp_n) $display("FAIL rnd%0d_cycles op %0d: got %0d want %0d", i, op, cyc, exp_n); else n_pass++;
                n_total++; if (sb != 0 || hb != 0) $display("FAIL rnd%0d_window op %0d: stall errs %0d hold errs %0d want 0", i, op, sb, hb); else n_pass++;
            end else begin
                run_short(op, a, d_use, st, bz);
                model_apply(op, a, b);
                n_total++; if (st !== 1'b0 || bz !== 1'b0) $display("FAIL rnd%0d_short op %0d: stall %b busy %b want 0/0", i, op, st, bz); else n_pass++;
            end
            n_total++; if (hi !== m_hi || lo !== m_lo)
                $display("FAIL rnd%0d_result op %0d a %h b %h: hi %h lo %h want %h/%h", i, op, a, b, hi, lo, m_hi, m_lo); else n_pass++;
        end
        n_total++; if (err_issue !== 1'b0) $display("FAIL rnd_err: got %b want 0", err_issue); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mult_basic();
        test_divu_stall();
        test_div_signed();
        test_mt_div0();
        test_err_issue();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
